// File: rtl/tb_event_responder.sv
// Loopback responder: turns SET value changes into delayed one-cycle WAIT pulses and CHECK levels.
// Optional build macro TB_EVENT_TIMESTAMP_EN adds a cycle counter and the o_timestamp output.
module tb_event_responder #(
  parameter int NB_CH      = 5,
  parameter int WIDTH      = 32,
  parameter int DELAY      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NB_CH*WIDTH-1:0]       i_set,
  output logic [NB_CH-1:0]             o_wait,
  output logic [NB_CH*WIDTH-1:0]       o_check,
  output logic [$clog2(FIFO_DEPTH):0]  o_pending,
  output logic                         o_overflow,
  input  logic                         i_clr_ovf,
`ifdef TB_EVENT_TIMESTAMP_EN
  output logic [31:0]                  o_timestamp,
`endif
  output logic [1:0]                   o_dbg_state
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int IDW = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam logic [7:0]  DLY_LOAD = 8'(DELAY - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // Handshake: the arbiter offers one push per cycle; it is accepted only when the FIFO is
  // not full, and the FSM pops only in IDLE with a non-empty FIFO. Pending clears either way.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DLY = 2'd1, S_FIRE = 2'd2} state_t;

  logic [NB_CH*WIDTH-1:0] s_prev_q, s_prev_d;
  logic [NB_CH*WIDTH-1:0] cap_q, cap_d;
  logic [NB_CH-1:0]       pending_q, pending_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   ovf_q, ovf_d;
  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [IDW-1:0]         hold_id_q, hold_id_d;
  logic [WIDTH-1:0]       hold_data_q, hold_data_d;
  logic [NB_CH-1:0]       wait_q, wait_d;
  logic [NB_CH*WIDTH-1:0] check_q, check_d;

  logic [IDW-1:0]         mem_id_q   [FIFO_DEPTH];
  logic [WIDTH-1:0]       mem_data_q [FIFO_DEPTH];

  logic                   push_req, push_ok, pop, full;
  logic [IDW-1:0]         push_id;
  logic [WIDTH-1:0]       push_data;

`ifdef TB_EVENT_TIMESTAMP_EN
  logic [31:0]            ts_cnt_q, ts_cnt_d;
  logic [31:0]            hold_ts_q, hold_ts_d;
  logic [31:0]            ts_out_q, ts_out_d;
  logic [31:0]            mem_ts_q [FIFO_DEPTH];
`endif

  // Descending scan so the lowest pending channel is the one left in push_id.
  always_comb begin
    push_req  = 1'b0;
    push_id   = '0;
    push_data = '0;
    for (int k = NB_CH - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        push_req  = 1'b1;
        push_id   = IDW'(k);
        push_data = cap_q[k*WIDTH +: WIDTH];
      end
    end
  end

  assign full    = (count_q == FULL_CNT);
  assign push_ok = push_req && !full;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    s_prev_d  = i_set;
    pending_d = pending_q;
    cap_d     = cap_q;
    for (int k = 0; k < NB_CH; k++) begin
      if (push_req && (push_id == IDW'(k))) pending_d[k] = 1'b0;
      if (i_set[k*WIDTH +: WIDTH] != s_prev_q[k*WIDTH +: WIDTH]) begin
        pending_d[k]              = 1'b1;
        cap_d[k*WIDTH +: WIDTH]   = i_set[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    if (push_req && full) ovf_d = 1'b1;
    else if (i_clr_ovf)   ovf_d = 1'b0;
    else                  ovf_d = ovf_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_id_d   = hold_id_q;
    hold_data_d = hold_data_q;
    wait_d      = '0;
    check_d     = check_q;
`ifdef TB_EVENT_TIMESTAMP_EN
    hold_ts_d   = hold_ts_q;
    ts_out_d    = ts_out_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          hold_id_d   = mem_id_q[rd_ptr_q];
          hold_data_d = mem_data_q[rd_ptr_q];
`ifdef TB_EVENT_TIMESTAMP_EN
          hold_ts_d   = mem_ts_q[rd_ptr_q];
`endif
          cnt_d       = DLY_LOAD;
          state_d     = S_DLY;
        end
      end
      S_DLY: begin
        if (cnt_q == '0) state_d = S_FIRE;
        else             cnt_d   = cnt_q - 8'd1;
      end
      S_FIRE: begin
        for (int k = 0; k < NB_CH; k++) begin
          if (hold_id_q == IDW'(k)) begin
            wait_d[k]                 = 1'b1;
            check_d[k*WIDTH +: WIDTH] = hold_data_q;
          end
        end
`ifdef TB_EVENT_TIMESTAMP_EN
        ts_out_d = hold_ts_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef TB_EVENT_TIMESTAMP_EN
  assign ts_cnt_d = ts_cnt_q + 32'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q    <= '0;
      cap_q       <= '0;
      pending_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_id_q   <= '0;
      hold_data_q <= '0;
      wait_q      <= '0;
      check_q     <= '0;
`ifdef TB_EVENT_TIMESTAMP_EN
      ts_cnt_q    <= '0;
      hold_ts_q   <= '0;
      ts_out_q    <= '0;
`endif
    end else begin
      s_prev_q    <= s_prev_d;
      cap_q       <= cap_d;
      pending_q   <= pending_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_id_q   <= hold_id_d;
      hold_data_q <= hold_data_d;
      wait_q      <= wait_d;
      check_q     <= check_d;
`ifdef TB_EVENT_TIMESTAMP_EN
      ts_cnt_q    <= ts_cnt_d;
      hold_ts_q   <= hold_ts_d;
      ts_out_q    <= ts_out_d;
`endif
    end
  end

  // Storage needs no reset: entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_id_q[wr_ptr_q]   <= push_id;
      mem_data_q[wr_ptr_q] <= push_data;
`ifdef TB_EVENT_TIMESTAMP_EN
      mem_ts_q[wr_ptr_q]   <= ts_cnt_q;
`endif
    end
  end

  assign o_wait      = wait_q;
  assign o_check     = check_q;
  assign o_pending   = count_q;
  assign o_overflow  = ovf_q;
  assign o_dbg_state = state_q;
`ifdef TB_EVENT_TIMESTAMP_EN
  assign o_timestamp = ts_out_q;
`endif

endmodule
